difftest_commit_queue: RTL and testbench
========================================

Name: difftest_commit_queue

Overview:
- Multi-channel successor to the single-lane commit test port used for difftest.
- Captures up to CHANNELS retired instructions per cycle from the commit stage, together with a per-entry mepc snapshot.
- Compacts them in program order into a circular FIFO and drains one entry per cycle to the simulation/difftest sink over a valid/ready handshake.
- Simulation and test use only; no effect on architectural state.

Parameters:
- XLEN, 64, register/PC width (matches `XLEN).
- CHANNELS, 2, commit lanes per cycle; 1..4. Lane 0 is the oldest.
- DEPTH, 16, FIFO entries; power of two, DEPTH >= CHANNELS.
- SEQW, 32, width of the commit sequence counter.

Ports:
- clk_i  in  1  clock.
- arst_n_i  in  1  asynchronous active-low reset.
- cmt_valid_i  in  CHANNELS  per-lane commit valid.
- cmt_pc_i  in  CHANNELS*XLEN  per-lane PC; lane k is at bits [k*XLEN +: XLEN].
- cmt_trap_i  in  CHANNELS  per-lane trap flag.
- cmt_wen_i  in  CHANNELS  per-lane int register write enable.
- cmt_windex_i  in  CHANNELS*5  per-lane destination index.
- cmt_wdata_i  in  CHANNELS*XLEN  per-lane write-back value.
- csr_mepc_i  in  XLEN  current mepc, sampled at enqueue.
- out_valid_o  out  1  head entry valid.
- out_ready_i  in  1  sink accepts head.
- out_pc_o  out  XLEN  head PC.
- out_trap_o  out  1  head trap flag.
- out_wen_o  out  1  head write enable.
- out_windex_o  out  5  head destination index.
- out_wdata_o  out  XLEN  head write-back value.
- out_mepc_o  out  XLEN  mepc captured with the head entry.
- out_seq_o  out  SEQW  head sequence number.
- count_o  out  $clog2(DEPTH+1)  current occupancy.
- overflow_o  out  1  sticky: a commit group was dropped.

Behaviour:
- Reset (arst_n_i low, asynchronous):
  - rd_ptr = wr_ptr = count = 0, seq counter = 0, overflow_o = 0, out_valid_o = 0.
  - Storage contents are don't-care; out_* data outputs read 0 while the queue is empty.
- Enqueue:
  - n = popcount(cmt_valid_i).
  - Valid lanes are compacted in ascending lane order into slots wr_ptr, wr_ptr+1, … modulo DEPTH. Gaps between valid lanes (e.g. lanes 0 and 2 valid) are allowed.
  - Each stored entry records pc, trap, wen, windex, wdata, csr_mepc_i of that cycle, and seq = seq counter + its compacted position.
  - wen is stored as 0 when windex == 0 (x0 writes are suppressed); wdata is stored as given.
  - The seq counter advances by n and wraps modulo 2^SEQW.
- Capacity is all-or-nothing:
  - Accept the group only if n <= DEPTH - count, using count at the start of the cycle. A dequeue in the same cycle does not create room.
  - Otherwise drop the whole group: no entry written, seq counter unchanged, overflow_o set to 1 on the next edge and held until reset.
- Dequeue:
  - out_valid_o = (count != 0); combinational from registered state, zero latency from storage to output.
  - Head advances when out_valid_o && out_ready_i.
  - out_* stay stable while out_valid_o && !out_ready_i.
- Latency: an entry committed in cycle t is visible at the head at t+1 when the queue was empty.
- Simultaneous enqueue and dequeue: count_next = count + accepted_n - deq. Both pointers wrap modulo DEPTH.
- n = 0 is a no-op enqueue. out_ready_i while empty is ignored.
- Reset asserted mid-burst discards all entries immediately. The sequence restarts at 0.

Decomposition:
- Shared package prv664_test_pkg:
  - typedef difftest_entry_t struct with fields pc, trap, wen, windex, wdata, mepc, seq.
  - A function returning popcount of a CHANNELS-bit vector.
- Sub-module difftest_commit_compact:
  - Combinational prefix-count over cmt_valid_i.
  - Outputs per-lane slot offset and total n, used to steer lanes to FIFO slots.
- Top level holds the storage array, pointers, count, seq counter and overflow flag.

Test Plan:
- Single lane: CHANNELS=2, one cycle with lane 0 valid, pc=0x8000_0000, wen=1, windex=5, wdata=0x1234, out_ready_i=1 -> next cycle out_valid_o=1, out_pc_o=0x8000_0000, out_wdata_o=0x1234, out_seq_o=0; cycle after, count_o=0.
- Compaction across a gap: CHANNELS=4, lanes 1 and 3 valid with pc=0x100 and 0x108 -> drain order 0x100 then 0x108, seq 0 then 1, count_o peaks at 2.
- x0 write suppression: lane 0 valid, wen=1, windex=0, wdata=0xFFFF -> out_wen_o=0 at head.
- Backpressure fill: out_ready_i=0, DEPTH=16, CHANNELS=2, commit 2 per cycle for 9 cycles -> after 8 cycles count_o=16; 9th group dropped; overflow_o=1; seq counter stays at 16 until the next accepted commit.
- Simultaneous enqueue/dequeue at full: count=16, out_ready_i=1, 1 lane valid -> group dropped, count_o=15, overflow_o=1.
- Reset mid-operation and trap capture:
  - 5 entries queued, arst_n_i pulsed low -> out_valid_o=0, count_o=0, overflow_o=0.
  - Then a trap commit with csr_mepc_i=0x8000_0040 -> out_trap_o=1, out_mepc_o=0x8000_0040, out_seq_o=0.

Source files
------------

// File: rtl/prv664_test_pkg.sv
// prv664_test_pkg: shared difftest entry type and lane popcount helper
package prv664_test_pkg;
   localparam int DT_XLEN = 64;
   localparam int DT_SEQW = 32;
   localparam int MAX_CH  = 4;
   typedef struct packed {
      logic [DT_XLEN-1:0] pc;
      logic               trap;
      logic               wen;
      logic [4:0]         windex;
      logic [DT_XLEN-1:0] wdata;
      logic [DT_XLEN-1:0] mepc;
      logic [DT_SEQW-1:0] seq;
   } difftest_entry_t;
   function automatic logic [2:0] popcount(input logic [MAX_CH-1:0] v);
      logic [2:0] c;
      c = '0;
      for (int i = 0; i < MAX_CH; i++) c = c + 3'(v[i]);
      return c;
   endfunction
endpackage

// File: rtl/difftest_commit_compact.sv
// difftest_commit_compact: prefix count of valid lanes giving each lane its slot offset
module difftest_commit_compact
   import prv664_test_pkg::*;
#(
   parameter int CHANNELS = 2
) (
   input  logic [CHANNELS-1:0]   valid_i,
   output logic [CHANNELS*3-1:0] offset_o,
   output logic [2:0]            n_o
);
   // each lane's offset is the number of valid lanes below it
   always_comb begin
      logic [2:0] acc;
      acc      = '0;
      offset_o = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         offset_o[k*3 +: 3] = acc;
         acc = acc + 3'(valid_i[k]);
      end
      n_o = popcount(MAX_CH'(valid_i));
   end
endmodule

// File: rtl/difftest_commit_queue.sv
// difftest_commit_queue: multi-lane commit capture into a circular FIFO drained one entry per cycle
module difftest_commit_queue
   import prv664_test_pkg::*;
#(
   parameter int XLEN     = 64,
   parameter int CHANNELS = 2,
   parameter int DEPTH    = 16,
   parameter int SEQW     = 32,
   localparam int PW      = $clog2(DEPTH),
   localparam int CW      = $clog2(DEPTH+1)
) (
   input  logic                     clk_i,
   input  logic                     arst_n_i,
   input  logic [CHANNELS-1:0]      cmt_valid_i,
   input  logic [CHANNELS*XLEN-1:0] cmt_pc_i,
   input  logic [CHANNELS-1:0]      cmt_trap_i,
   input  logic [CHANNELS-1:0]      cmt_wen_i,
   input  logic [CHANNELS*5-1:0]    cmt_windex_i,
   input  logic [CHANNELS*XLEN-1:0] cmt_wdata_i,
   input  logic [XLEN-1:0]          csr_mepc_i,
   output logic                     out_valid_o,
   input  logic                     out_ready_i,
   output logic [XLEN-1:0]          out_pc_o,
   output logic                     out_trap_o,
   output logic                     out_wen_o,
   output logic [4:0]               out_windex_o,
   output logic [XLEN-1:0]          out_wdata_o,
   output logic [XLEN-1:0]          out_mepc_o,
   output logic [SEQW-1:0]          out_seq_o,
   output logic [CW-1:0]            count_o,
   output logic                     overflow_o
);
   difftest_entry_t       mem_q [DEPTH];
   difftest_entry_t       ent   [CHANNELS];
   logic [PW-1:0]         slot  [CHANNELS];
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic [SEQW-1:0]       seq_q, seq_d;
   logic                  overflow_q, overflow_d;
   logic [CHANNELS*3-1:0] offset;
   logic [2:0]            n;
   logic                  fits, accept, deq;
   difftest_entry_t       head;

   difftest_commit_compact #(.CHANNELS(CHANNELS)) u_compact (
      .valid_i  (cmt_valid_i),
      .offset_o (offset),
      .n_o      (n)
   );

   // build per-lane entries and their target slots; x0 writes lose their enable
   always_comb begin
      for (int k = 0; k < CHANNELS; k++) begin
         slot[k]       = wr_ptr_q + PW'(offset[k*3 +: 3]);
         ent[k].pc     = DT_XLEN'(cmt_pc_i[k*XLEN +: XLEN]);
         ent[k].trap   = cmt_trap_i[k];
         ent[k].wen    = cmt_wen_i[k] && (cmt_windex_i[k*5 +: 5] != 5'd0);
         ent[k].windex = cmt_windex_i[k*5 +: 5];
         ent[k].wdata  = DT_XLEN'(cmt_wdata_i[k*XLEN +: XLEN]);
         ent[k].mepc   = DT_XLEN'(csr_mepc_i);
         ent[k].seq    = DT_SEQW'(seq_q + SEQW'(offset[k*3 +: 3]));
      end
   end

   // capacity uses start-of-cycle occupancy so a same-cycle dequeue never makes room
   always_comb begin
      fits       = CW'(n) <= CW'(DEPTH) - count_q;
      accept     = fits && (n != 3'd0);
      deq        = out_valid_o && out_ready_i;
      wr_ptr_d   = accept ? wr_ptr_q + PW'(n) : wr_ptr_q;
      rd_ptr_d   = deq ? rd_ptr_q + PW'(1) : rd_ptr_q;
      count_d    = count_q + (accept ? CW'(n) : CW'(0)) - CW'(deq);
      seq_d      = accept ? seq_q + SEQW'(n) : seq_q;
      overflow_d = overflow_q || !fits;
   end

   // control state with asynchronous clear
   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         seq_q      <= '0;
         overflow_q <= 1'b0;
      end else begin
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         seq_q      <= seq_d;
         overflow_q <= overflow_d;
      end
   end

   // storage write of the accepted group, no reset needed
   always_ff @(posedge clk_i) begin
      if (accept)
         for (int k = 0; k < CHANNELS; k++)
            if (cmt_valid_i[k]) mem_q[slot[k]] <= ent[k];
   end

   // head presentation, forced to zero while empty
   always_comb begin
      out_valid_o  = count_q != '0;
      head         = out_valid_o ? mem_q[rd_ptr_q] : '0;
      out_pc_o     = head.pc[XLEN-1:0];
      out_trap_o   = head.trap;
      out_wen_o    = head.wen;
      out_windex_o = head.windex;
      out_wdata_o  = head.wdata[XLEN-1:0];
      out_mepc_o   = head.mepc[XLEN-1:0];
      out_seq_o    = head.seq[SEQW-1:0];
      count_o      = count_q;
      overflow_o   = overflow_q;
   end
endmodule

// File: tb/tb_difftest_commit_queue.sv
// tb_difftest_commit_queue: directed checks of the commit queue with four lanes
module tb_difftest_commit_queue;
   logic         clk_i = 1'b0;
   logic         arst_n_i = 1'b0;
   logic [3:0]   cmt_valid_i, cmt_trap_i, cmt_wen_i;
   logic [255:0] cmt_pc_i, cmt_wdata_i;
   logic [19:0]  cmt_windex_i;
   logic [63:0]  csr_mepc_i;
   logic         out_valid_o, out_ready_i, out_trap_o, out_wen_o, overflow_o;
   logic [63:0]  out_pc_o, out_wdata_o, out_mepc_o;
   logic [4:0]   out_windex_o, count_o;
   logic [31:0]  out_seq_o;
   int checks = 0;
   int errors = 0;

   difftest_commit_queue #(.XLEN(64), .CHANNELS(4), .DEPTH(16), .SEQW(32)) dut (
      .clk_i(clk_i), .arst_n_i(arst_n_i), .cmt_valid_i(cmt_valid_i), .cmt_pc_i(cmt_pc_i),
      .cmt_trap_i(cmt_trap_i), .cmt_wen_i(cmt_wen_i), .cmt_windex_i(cmt_windex_i),
      .cmt_wdata_i(cmt_wdata_i), .csr_mepc_i(csr_mepc_i), .out_valid_o(out_valid_o),
      .out_ready_i(out_ready_i), .out_pc_o(out_pc_o), .out_trap_o(out_trap_o),
      .out_wen_o(out_wen_o), .out_windex_o(out_windex_o), .out_wdata_o(out_wdata_o),
      .out_mepc_o(out_mepc_o), .out_seq_o(out_seq_o), .count_o(count_o), .overflow_o(overflow_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic clear();
      cmt_valid_i = '0; cmt_trap_i = '0; cmt_wen_i = '0;
      cmt_pc_i = '0; cmt_wdata_i = '0; cmt_windex_i = '0; csr_mepc_i = '0;
   endtask

   task automatic lane(input int k, input logic [63:0] pc, input logic trap, input logic wen,
                       input logic [4:0] idx, input logic [63:0] wd);
      cmt_valid_i[k] = 1'b1;
      cmt_pc_i[k*64 +: 64] = pc;
      cmt_trap_i[k] = trap;
      cmt_wen_i[k] = wen;
      cmt_windex_i[k*5 +: 5] = idx;
      cmt_wdata_i[k*64 +: 64] = wd;
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic pulse_reset();
      arst_n_i = 1'b0;
      #2;
      arst_n_i = 1'b1;
   endtask

   initial begin
      clear();
      out_ready_i = 1'b0;
      #3;
      check("rst_valid", 64'(out_valid_o), 64'd0);
      check("rst_count", 64'(count_o), 64'd0);
      check("rst_ovf", 64'(overflow_o), 64'd0);
      check("rst_pc", out_pc_o, 64'd0);
      arst_n_i = 1'b1;
      step();
      // single lane, zero-latency head
      out_ready_i = 1'b1;
      lane(0, 64'h8000_0000, 1'b0, 1'b1, 5'd5, 64'h1234);
      step();
      clear();
      check("sl_valid", 64'(out_valid_o), 64'd1);
      check("sl_pc", out_pc_o, 64'h8000_0000);
      check("sl_wdata", out_wdata_o, 64'h1234);
      check("sl_wen", 64'(out_wen_o), 64'd1);
      check("sl_widx", 64'(out_windex_o), 64'd5);
      check("sl_seq", 64'(out_seq_o), 64'd0);
      step();
      check("sl_count", 64'(count_o), 64'd0);
      check("sl_empty", 64'(out_valid_o), 64'd0);
      // compaction across a gap
      pulse_reset();
      out_ready_i = 1'b0;
      lane(1, 64'h100, 1'b0, 1'b0, 5'd1, 64'h0);
      lane(3, 64'h108, 1'b0, 1'b0, 5'd2, 64'h0);
      step();
      clear();
      check("gap_count", 64'(count_o), 64'd2);
      out_ready_i = 1'b1;
      check("gap_pc0", out_pc_o, 64'h100);
      check("gap_seq0", 64'(out_seq_o), 64'd0);
      step();
      check("gap_pc1", out_pc_o, 64'h108);
      check("gap_seq1", 64'(out_seq_o), 64'd1);
      check("gap_count1", 64'(count_o), 64'd1);
      step();
      check("gap_drain", 64'(count_o), 64'd0);
      // x0 write suppression
      out_ready_i = 1'b0;
      lane(0, 64'h300, 1'b0, 1'b1, 5'd0, 64'hFFFF);
      step();
      clear();
      check("x0_wen", 64'(out_wen_o), 64'd0);
      check("x0_wdata", out_wdata_o, 64'hFFFF);
      check("x0_seq", 64'(out_seq_o), 64'd2);
      out_ready_i = 1'b1;
      step();
      check("x0_drain", 64'(count_o), 64'd0);
      // backpressure fill, then overflow
      pulse_reset();
      out_ready_i = 1'b0;
      for (int i = 0; i < 9; i++) begin
         clear();
         lane(0, 64'h1000 + 64'(16*i), 1'b0, 1'b0, 5'd3, 64'(i));
         lane(1, 64'h1008 + 64'(16*i), 1'b0, 1'b0, 5'd4, 64'(i));
         step();
         if (i == 7) begin
            check("fill_count8", 64'(count_o), 64'd16);
            check("fill_ovf8", 64'(overflow_o), 64'd0);
         end
      end
      clear();
      check("fill_count9", 64'(count_o), 64'd16);
      check("fill_ovf9", 64'(overflow_o), 64'd1);
      check("fill_head_pc", out_pc_o, 64'h1000);
      check("fill_head_seq", 64'(out_seq_o), 64'd0);
      // enqueue while full and draining still drops
      out_ready_i = 1'b1;
      lane(0, 64'h2000, 1'b0, 1'b0, 5'd1, 64'h0);
      step();
      clear();
      check("full_count", 64'(count_o), 64'd15);
      check("full_ovf", 64'(overflow_o), 64'd1);
      check("full_head_pc", out_pc_o, 64'h1008);
      out_ready_i = 1'b0;
      lane(0, 64'h3000, 1'b0, 1'b0, 5'd1, 64'h0);
      step();
      clear();
      check("refill_count", 64'(count_o), 64'd16);
      out_ready_i = 1'b1;
      for (int i = 1; i < 16; i++) begin
         check($sformatf("drain_seq%0d", i), 64'(out_seq_o), 64'(i));
         check($sformatf("drain_pc%0d", i), out_pc_o, 64'h1000 + 64'(8*i));
         step();
      end
      check("seq_resume", 64'(out_seq_o), 64'd16);
      check("seq_resume_pc", out_pc_o, 64'h3000);
      step();
      check("drain_empty", 64'(count_o), 64'd0);
      check("drain_ovf", 64'(overflow_o), 64'd1);
      // mid-operation reset, then trap capture
      out_ready_i = 1'b0;
      for (int k = 0; k < 4; k++) lane(k, 64'h400 + 64'(4*k), 1'b0, 1'b1, 5'(k+1), 64'(k));
      step();
      clear();
      lane(0, 64'h410, 1'b0, 1'b1, 5'd7, 64'h7);
      step();
      clear();
      check("mid_count", 64'(count_o), 64'd5);
      arst_n_i = 1'b0;
      #1;
      check("mid_rst_valid", 64'(out_valid_o), 64'd0);
      check("mid_rst_count", 64'(count_o), 64'd0);
      check("mid_rst_ovf", 64'(overflow_o), 64'd0);
      arst_n_i = 1'b1;
      lane(0, 64'h200, 1'b1, 1'b0, 5'd0, 64'h0);
      csr_mepc_i = 64'h8000_0040;
      step();
      clear();
      check("trap_flag", 64'(out_trap_o), 64'd1);
      check("trap_mepc", out_mepc_o, 64'h8000_0040);
      check("trap_seq", 64'(out_seq_o), 64'd0);
      check("trap_pc", out_pc_o, 64'h200);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
